// File: rtl/top_cdt_pkg.sv
// rtl/top_cdt_pkg.sv - shared Top CDT trigger constants and helpers
package top_cdt_pkg;

  localparam int NTYPE_DEFAULT = 4;

  localparam int TRIG_DELTA = 0;
  localparam int TRIG_ET    = 1;
  localparam int TRIG_VETO  = 2;
  localparam int TRIG_CLK   = 3;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Run counters stick at CNT_MAX instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/trig_prescaler.sv
// rtl/trig_prescaler.sv - per-type request prescaler
module trig_prescaler #(
  parameter int PS_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            req,
  input  logic            hold,
  input  logic [PS_W-1:0] prescale,
  output logic            pass,
  output logic            armed
);

  localparam logic [PS_W-1:0] ONE = PS_W'(1);

  logic [PS_W-1:0] cnt_q, cnt_d;
  logic            en;

  // Armed means the next accepted request passes; >= lets a lowered prescale take effect at once.
  always_comb begin
    en    = (prescale != '0);
    armed = en && (cnt_q >= (prescale - ONE));
    pass  = req && !hold && armed;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (req && en && !hold) begin
      cnt_d = armed ? '0 : cnt_q + ONE;
    end
  end

  // Request counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/trig_lv1a_merge.sv
// rtl/trig_lv1a_merge.sv - merges per-type LV1A requests into one deadtime-limited pulse
module trig_lv1a_merge
  import top_cdt_pkg::*;
#(
  parameter int NTYPE = NTYPE_DEFAULT,
  parameter int PS_W  = 16,
  parameter int DT_W  = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_live,
  input  logic [NTYPE-1:0]        in_trig,
  input  logic [NTYPE-1:0]        user_ena,
  input  logic [NTYPE*PS_W-1:0]   prescale,
  input  logic [DT_W-1:0]         deadtime,
  output logic                    out_lv1a,
  output logic [NTYPE-1:0]        out_type,
  output logic                    busy,
  output logic [31:0]             ntrig,
  output logic [31:0]             nraw,
  output logic [31:0]             nlost
);

  localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);

  logic [NTYPE-1:0] ps_en, req, pass, armed;
  logic             ps_clr;

  logic             live_q, live_d;
  logic             out_lv1a_q, out_lv1a_d;
  logic [NTYPE-1:0] out_type_q, out_type_d;
  logic [DT_W-1:0]  dt_cnt_q, dt_cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      ntrig_q, ntrig_d;
  logic [31:0]      nraw_q, nraw_d;
  logic [31:0]      nlost_q, nlost_d;

  logic             live_rise, pass_any, raw_any, lost_any;

  assign ps_clr = ~in_live;

  for (genvar i = 0; i < NTYPE; i++) begin : g_ps
    assign ps_en[i] = (prescale[i*PS_W +: PS_W] != '0);

    trig_prescaler #(.PS_W(PS_W)) u_ps (
      .clk      (clk),
      .rst      (rst),
      .clr      (ps_clr),
      .req      (req[i]),
      .hold     (busy_q),
      .prescale (prescale[i*PS_W +: PS_W]),
      .pass     (pass[i]),
      .armed    (armed[i])
    );
  end

  // Qualify requests, merge passes, run deadtime and counters; a count in the live-rise cycle beats the clear.
  always_comb begin
    req       = in_trig & user_ena & ps_en & {NTYPE{in_live}};
    live_rise = in_live & ~live_q;
    pass_any  = |pass;
    raw_any   = |req;
    lost_any  = busy_q & |(req & armed);

    live_d     = in_live;
    out_lv1a_d = pass_any;

    out_type_d = live_rise ? '0 : out_type_q;
    if (pass_any) out_type_d = pass;

    dt_cnt_d = '0;
    if (in_live) begin
      if (pass_any)              dt_cnt_d = deadtime;
      else if (dt_cnt_q != '0)   dt_cnt_d = dt_cnt_q - DT_ONE;
    end
    busy_d = (dt_cnt_d != '0);

    ntrig_d = sat_inc(live_rise ? 32'd0 : ntrig_q, pass_any);
    nraw_d  = sat_inc(live_rise ? 32'd0 : nraw_q,  raw_any);
    nlost_d = sat_inc(live_rise ? 32'd0 : nlost_q, lost_any);
  end

  // Output and state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q     <= 1'b0;
      out_lv1a_q <= 1'b0;
      out_type_q <= '0;
      dt_cnt_q   <= '0;
      busy_q     <= 1'b0;
      ntrig_q    <= '0;
      nraw_q     <= '0;
      nlost_q    <= '0;
    end else begin
      live_q     <= live_d;
      out_lv1a_q <= out_lv1a_d;
      out_type_q <= out_type_d;
      dt_cnt_q   <= dt_cnt_d;
      busy_q     <= busy_d;
      ntrig_q    <= ntrig_d;
      nraw_q     <= nraw_d;
      nlost_q    <= nlost_d;
    end
  end

  assign out_lv1a = out_lv1a_q;
  assign out_type = out_type_q;
  assign busy     = busy_q;
  assign ntrig    = ntrig_q;
  assign nraw     = nraw_q;
  assign nlost    = nlost_q;

endmodule
